// File: rtl/nor_chain_pkg.sv
// -----------------------------------------------------------------------------
// nor_chain_pkg
// Shared constants and helpers for the pipelined NOR/NAND cascade.
//   MODE_NOR / MODE_NAND : encoding of the per-transaction gate select
//   word_lo()            : low bit index of word k in a WIDTH-wide packed bus
// -----------------------------------------------------------------------------
package nor_chain_pkg;

    localparam logic MODE_NOR  = 1'b0;
    localparam logic MODE_NAND = 1'b1;

    // Operand/tap slice index: word k of a bus occupies [k*width +: width].
    function automatic int word_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/nor_chain_stage.sv
// -----------------------------------------------------------------------------
// nor_chain_stage
// One level of the elastic cascade. Computes r_K = op(a, d(K)) and registers
// it together with the earlier taps r_1..r_(K-1) and the still-pending
// operands d(K+1)..d(N_IN-1).
//
// Bus layout between stages (N_IN*WIDTH bits, word index in brackets):
//   [0]            a operand for the next level (d0 into stage 1, r_K out of stage K)
//   [1 .. K]       taps r_1..r_K        (out of stage K)
//   [K+1 .. N_IN-1] pending operands d(K+1)..d(N_IN-1)
// Into stage K the same layout holds with K-1 taps, so d(K) sits at word K.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   up_valid/up_ready   handshake with the previous level (or the source)
//   up_mode, up_data    transaction entering this level
//   dn_valid/dn_ready   handshake with the next level (or the sink)
//   dn_mode, dn_data    registered transaction leaving this level
// -----------------------------------------------------------------------------
module nor_chain_stage
    import nor_chain_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int K     = 1,
    parameter int N_IN  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic                    up_mode,
    input  logic [N_IN*WIDTH-1:0]   up_data,
    output logic                    dn_valid,
    input  logic                    dn_ready,
    output logic                    dn_mode,
    output logic [N_IN*WIDTH-1:0]   dn_data
);

    localparam int SW = (N_IN - 1) * WIDTH;

    if ((K < 1) || (K > N_IN - 1)) begin : g_bad_k
        $error("nor_chain_stage: K must lie in 1..N_IN-1");
    end

    logic          valid_q, valid_d;
    logic          mode_q,  mode_d;
    logic [SW-1:0] state_q, state_d;   // {pending operands, r_K, r_(K-1)..r_1}

    logic [WIDTH-1:0] a_w, b_w, r_w;

    assign a_w = up_data[word_lo(0, WIDTH) +: WIDTH];
    assign b_w = up_data[word_lo(K, WIDTH) +: WIDTH];
    assign r_w = (up_mode == MODE_NAND) ? ~(a_w & b_w) : ~(a_w | b_w);

    // An empty level always loads, so bubbles collapse toward the output.
    assign up_ready = ~valid_q | dn_ready;

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        state_d = state_q;
        if (up_ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                mode_d  = up_mode;
                // Drop the consumed 'a' word; d(K) is replaced in place by r_K,
                // which leaves taps below and pending operands above it.
                state_d = up_data[N_IN*WIDTH-1:WIDTH];
                state_d[word_lo(K - 1, WIDTH) +: WIDTH] = r_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_NOR;
            state_q <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_mode  = mode_q;
    // Latest result is duplicated into word 0 as the next level's 'a' operand.
    assign dn_data  = {state_q, state_q[word_lo(K - 1, WIDTH) +: WIDTH]};

endmodule

// File: rtl/nor_chain_pipe.sv
// -----------------------------------------------------------------------------
// nor_chain_pipe
// Pipelined, parametrised NOR/NAND cascade: r1 = op(d0,d1), rk = op(r(k-1),dk),
// one register level per cascade step (latency N_IN-1), elastic valid/ready on
// both sides, every intermediate result exported as a delay-matched tap.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   source handshake (in_ready is combinational)
//   in_data               operand k at [k*WIDTH +: WIDTH]
//   in_mode               0 = NOR cascade, 1 = NAND cascade, per transaction
//   out_valid / out_ready sink handshake
//   out_data              final result r(N_IN-1)
//   out_taps              r_k at [(k-1)*WIDTH +: WIDTH]; top slice equals out_data
// -----------------------------------------------------------------------------
module nor_chain_pipe
    import nor_chain_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_IN  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*WIDTH-1:0]       in_data,
    input  logic                        in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [(N_IN-1)*WIDTH-1:0]   out_taps
);

    if (N_IN < 2) begin : g_bad_n_in
        $error("nor_chain_pipe: N_IN must be at least 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("nor_chain_pipe: WIDTH must be at least 1");
    end

    // Index 0 is the source side; index k is the output of level k.
    logic [N_IN-1:0]        valid_chain;
    logic [N_IN-1:0]        mode_chain;
    logic [N_IN*WIDTH-1:0]  data_chain [N_IN];
    // rdy_chain[k] = ready of level k; rdy_chain[N_IN] is the sink.
    logic [N_IN:1]          rdy_chain;

    assign valid_chain[0]  = in_valid;
    assign mode_chain[0]   = in_mode;
    assign data_chain[0]   = in_data;
    assign rdy_chain[N_IN] = out_ready;

    for (genvar gi = 1; gi < N_IN; gi++) begin : g_stage
        nor_chain_stage #(
            .WIDTH (WIDTH),
            .K     (gi),
            .N_IN  (N_IN)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid_chain[gi-1]),
            .up_ready (rdy_chain[gi]),
            .up_mode  (mode_chain[gi-1]),
            .up_data  (data_chain[gi-1]),
            .dn_valid (valid_chain[gi]),
            .dn_ready (rdy_chain[gi+1]),
            .dn_mode  (mode_chain[gi]),
            .dn_data  (data_chain[gi])
        );
    end

    assign in_ready  = rdy_chain[1];
    assign out_valid = valid_chain[N_IN-1];
    assign out_data  = data_chain[N_IN-1][word_lo(0, WIDTH) +: WIDTH];
    assign out_taps  = data_chain[N_IN-1][word_lo(1, WIDTH) +: (N_IN-1)*WIDTH];

endmodule
